// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character-LCD sequencer.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
  } lcd_state_e;

  localparam int ON_BIT      = 31;
  localparam int BLON_BIT    = 30;
  localparam int CLR_OVF_BIT = 29;
  localparam int RS_BIT      = 8;

  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_T_SETUP     = 4;
  localparam int DEF_T_EN        = 12;
  localparam int DEF_T_HOLD      = 2;
  localparam int DEF_T_EXEC      = 2000;
  localparam int DEF_T_EXEC_LONG = 82000;

  localparam int TIMER_W = 17;

  localparam logic [7:0] CLR_HOME_MAX = 8'h03;

  // Clear-display and return-home need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
    return !rs && (b <= CLR_HOME_MAX);
  endfunction

endpackage

// File: rtl/lcd_if.sv
// Store/load-path connection between the load/store unit and the LCD sequencer.
// i_wr_en is a one-cycle store strobe with no back-pressure; acceptance is
// reported afterwards through o_status (busy = bit 0, overflow = bit 1).
interface lcd_if;
  logic        i_wr_en;
  logic [31:0] i_wr_data;
  logic [31:0] o_status;

  modport master (output i_wr_en, output i_wr_data, input  o_status);
  modport slave  (input  i_wr_en, input  i_wr_data, output o_status);
endinterface

// File: rtl/lcd_fifo.sv
// 9-bit synchronous FIFO holding queued {RS, byte} LCD writes.
module lcd_fifo
  import lcd_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [8:0]               i_din,
  output logic [8:0]               o_dout,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [8:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/lcd_driver.sv
// HD44780 write sequencer: queues stores, then times setup, EN pulse, hold and execution wait.
module lcd_driver
  import lcd_pkg::*;
#(
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int T_SETUP     = DEF_T_SETUP,
  parameter int T_EN        = DEF_T_EN,
  parameter int T_HOLD      = DEF_T_HOLD,
  parameter int T_EXEC      = DEF_T_EXEC,
  parameter int T_EXEC_LONG = DEF_T_EXEC_LONG
) (
  input  logic       i_clk,
  input  logic       i_reset,
  lcd_if.slave       bus,
  output logic [7:0] o_lcd_data,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_en,
  output logic       o_lcd_on,
  output logic       o_lcd_blon,
  output lcd_state_e o_dbg_state
);

  localparam logic [TIMER_W-1:0] T_SETUP_M1 = TIMER_W'(T_SETUP - 1);
  localparam logic [TIMER_W-1:0] T_EN_M1    = TIMER_W'(T_EN - 1);
  localparam logic [TIMER_W-1:0] T_HOLD_M1  = TIMER_W'(T_HOLD - 1);
  localparam logic [TIMER_W-1:0] T_EXEC_M1  = TIMER_W'(T_EXEC - 1);
  localparam logic [TIMER_W-1:0] T_LONG_M1  = TIMER_W'(T_EXEC_LONG - 1);

  lcd_state_e                r_state, w_state_nxt;
  logic [TIMER_W-1:0]        r_timer, w_timer_nxt;
  logic [7:0]                r_data;
  logic                      r_rs;
  logic                      r_ovf;
  logic                      r_on;
  logic                      r_blon;
  logic                      w_pop;
  logic                      w_enq;
  logic                      w_clr;
  logic                      w_drop;
  logic                      w_empty;
  logic                      w_full;
  logic [8:0]                w_head;
  logic [$clog2(FIFO_DEPTH):0] w_count;
  logic                      w_busy;
  logic                      w_unused_bits;

  assign w_clr  = bus.i_wr_en &&  bus.i_wr_data[CLR_OVF_BIT];
  assign w_enq  = bus.i_wr_en && !bus.i_wr_data[CLR_OVF_BIT];
  assign w_drop = w_enq && w_full && !w_pop;
  assign w_unused_bits = &{1'b0, bus.i_wr_data[28:9]};

  lcd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_enq),
    .i_pop   (w_pop),
    .i_din   ({bus.i_wr_data[RS_BIT], bus.i_wr_data[7:0]}),
    .o_dout  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_SETUP;
          w_timer_nxt = T_SETUP_M1;
        end
      end
      ST_SETUP: begin
        if (r_timer == '0) begin
          w_state_nxt = ST_PULSE;
          w_timer_nxt = T_EN_M1;
        end else w_timer_nxt = r_timer - TIMER_W'(1);
      end
      ST_PULSE: begin
        if (r_timer == '0) begin
          w_state_nxt = ST_HOLD;
          w_timer_nxt = T_HOLD_M1;
        end else w_timer_nxt = r_timer - TIMER_W'(1);
      end
      ST_HOLD: begin
        if (r_timer == '0) begin
          w_state_nxt = ST_WAIT;
          w_timer_nxt = is_long_cmd(r_rs, r_data) ? T_LONG_M1 : T_EXEC_M1;
        end else w_timer_nxt = r_timer - TIMER_W'(1);
      end
      ST_WAIT: begin
        if (r_timer == '0) w_state_nxt = ST_IDLE;
        else               w_timer_nxt = r_timer - TIMER_W'(1);
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // Pins only change on the pop so the LCD sees stable RS/DB through hold.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_data <= '0;
      r_rs   <= 1'b0;
    end else if (w_pop) begin
      r_data <= w_head[7:0];
      r_rs   <= w_head[8];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ovf  <= 1'b0;
      r_on   <= 1'b0;
      r_blon <= 1'b0;
    end else begin
      if (w_clr)       r_ovf <= 1'b0;
      else if (w_drop) r_ovf <= 1'b1;
      if (bus.i_wr_en) begin
        r_on   <= bus.i_wr_data[ON_BIT];
        r_blon <= bus.i_wr_data[BLON_BIT];
      end
    end
  end

  assign w_busy       = (r_state != ST_IDLE) || (w_count != '0);
  assign bus.o_status = {30'b0, r_ovf, w_busy};
  assign o_lcd_data   = r_data;
  assign o_lcd_rs     = r_rs;
  assign o_lcd_rw     = 1'b0;
  assign o_lcd_en     = (r_state == ST_PULSE);
  assign o_lcd_on     = r_on;
  assign o_lcd_blon   = r_blon;
  assign o_dbg_state  = r_state;

endmodule
